// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the sequential signed divider.
// Holds the controller state encoding and the iteration counter sizing rule.
package divider_pkg;

  // Controller states: wait for operands, iterate, correct signs, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Width of the iteration counter for a given dividend width.
  // A single-bit dividend still needs one counter bit to hold the value 0.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divider_seq_adder.sv
// divider_seq_adder: the datapath adder building block, reused here as the
// trial subtractor of the divider. The caller supplies an already negated
// operand on b, and the sum is arithmetically scaled down by OUT_SCALE bits.
module divider_seq_adder #(
  parameter int WIDTH     = 17,
  parameter int OUT_SCALE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic signed [WIDTH-1:0] raw_sum;

  // Two's-complement add, then an arithmetic right shift for output scaling.
  always_comb begin
    raw_sum = signed'(a + b);
    sum     = raw_sum >>> OUT_SCALE;
  end

endmodule

// File: rtl/divider_seq.sv
// divider_seq: iterative signed integer divider with valid/ready handshakes.
// It produces one quotient bit per clock by restoring trial subtraction on
// operand magnitudes, then applies signs in a single correction cycle.
// The quotient truncates toward zero and the remainder follows the dividend's
// sign. A zero divisor yields quotient -1 and remainder = dividend.
// Optional feature macro: DIVIDER_DBZ_FLAG_EN adds the div_by_zero output.
module divider_seq
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic                      div_by_zero
`endif
);

  localparam int W  = DIVIDEND_WIDTH;
  localparam int D  = DIVISOR_WIDTH;
  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  // Controller state and the registered handshake outputs.
  div_state_t state;
  div_state_t state_nxt;
  logic       in_ready_nxt;
  logic       out_valid_nxt;

  // Operand-side datapath registers. dvd_shift starts as |dividend| and is
  // shifted left each iteration; quotient bits fill it from the bottom, so
  // after W iterations it holds |quotient|. The partial remainder is one bit
  // wider than the divisor so that |most-negative divisor| is representable.
  logic [W-1:0]  dvd_shift;
  logic [D:0]    part_rem;
  logic [D:0]    neg_dvs_mag;
  logic          neg_quot;
  logic          neg_rem;
  logic          dvs_zero;
  logic [W-1:0]  dvd_raw;
  logic [CW-1:0] cnt;

  // Combinational helpers.
  logic          accept;
  logic          release_out;
  logic [W-1:0]  dvd_mag;
  logic [D:0]    dvs_ext;
  logic [D:0]    dvs_neg_mag_in;
  logic [D:0]    shifted_rem;
  logic [D:0]    trial;
  logic          qbit;
  logic [W-1:0]  quot_fix;
  logic [D-1:0]  rem_mag;
  logic [D-1:0]  rem_fix;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;

  // Operand conditioning at acceptance: dividend magnitude, and the negated
  // divisor magnitude fed to the adder. A negative divisor is already -|d|,
  // so only a non-negative divisor needs negating.
  always_comb begin
    dvd_mag        = dividend[W-1] ? -dividend : dividend;
    dvs_ext        = {divisor[D-1], divisor};
    dvs_neg_mag_in = divisor[D-1] ? dvs_ext : -dvs_ext;
  end

  // Bring the next dividend bit (MSB first) into the partial remainder.
  always_comb begin
    shifted_rem = {part_rem[D-1:0], dvd_shift[W-1]};
  end

  divider_seq_adder #(
    .WIDTH    (D + 1),
    .OUT_SCALE(0)
  ) u_trial_sub (
    .a  (shifted_rem),
    .b  (neg_dvs_mag),
    .sum(trial)
  );

  // A non-negative trial difference means the divisor fits: quotient bit 1.
  always_comb begin
    qbit = ~trial[D];
  end

  // Sign correction of the final magnitudes.
  always_comb begin
    rem_mag  = part_rem[D-1:0];
    quot_fix = neg_quot ? -dvd_shift : dvd_shift;
    rem_fix  = neg_rem ? -rem_mag : rem_mag;
  end

  // Next-state logic plus next values of the registered handshake outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state == DONE) && (state_nxt == DONE);
  end

  // State register and handshake outputs; all clear on reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Iteration datapath: load operands on acceptance, then one restoring
  // division step per CALC cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dvd_shift   <= '0;
      part_rem    <= '0;
      neg_dvs_mag <= '0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      dvs_zero    <= 1'b0;
      dvd_raw     <= '0;
      cnt         <= '0;
    end else begin
      if (state == IDLE && accept) begin
        dvd_shift   <= dvd_mag;
        part_rem    <= '0;
        neg_dvs_mag <= dvs_neg_mag_in;
        neg_quot    <= dividend[W-1] ^ divisor[D-1];
        neg_rem     <= dividend[W-1];
        dvs_zero    <= (divisor == '0);
        dvd_raw     <= dividend;
        cnt         <= '0;
      end else if (state == CALC) begin
        part_rem  <= qbit ? trial : shifted_rem;
        dvd_shift <= {dvd_shift[W-2:0], qbit};
        cnt       <= cnt + 1'b1;
      end
    end
  end

  // Result registers, loaded once in FIX and held until the next FIX.
  // A zero divisor overrides the iterated value with -1 / dividend.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (state == FIX) begin
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= D'(signed'(dvd_raw));
      end else begin
        quotient  <= quot_fix;
        remainder <= rem_fix;
      end
    end
  end

`ifdef DIVIDER_DBZ_FLAG_EN
  // Divide-by-zero flag travels with the result and clears when it is taken.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      div_by_zero <= 1'b0;
    end else if (state == FIX) begin
      div_by_zero <= dvs_zero;
    end else if (release_out) begin
      div_by_zero <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: scoreboard bench for divider_seq. Stimulus pushes the
// hand-computed expected result when a pair is accepted; an independent
// monitor pops and compares whenever a result is handed off.
module tb_divider_seq;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         arst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [D-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [D-1:0] remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic         div_by_zero;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [D-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];

  divider_seq #(
    .DIVIDEND_WIDTH(W),
    .DIVISOR_WIDTH (D)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Offer a pair, wait (bounded) for acceptance, optionally record the
  // expected result at the accepting edge. Returns at accept edge + 1 ns.
  task automatic applyStimulus(input int a, input int b, input int eq,
                               input int er, input bit edbz, input bit push);
    exp_t e;
    int   n;
    dividend = 16'(a);
    divisor  = 16'(b);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.q   = 16'(eq);
      e.r   = 16'(er);
      e.dbz = edbz;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen (bounded).
  task automatic waitOutput(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL output_timeout actual=out_valid_low required=out_valid_high");
    end
  endtask

  // Monitor: compare every handed-off result against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!arst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=q 0x%0h r 0x%0h required=no_result",
                 quotient, remainder);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", 32'(quotient), 32'(e.q));
        checkOutput("remainder", 32'(remainder), 32'(e.r));
`ifdef DIVIDER_DBZ_FLAG_EN
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int n;
    arst      = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    // Reset state.
    #2;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
`ifdef DIVIDER_DBZ_FLAG_EN
    checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_before_first_clock", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_first_clock", 32'(in_ready), 32'd1);

    // Basic division with latency measurement.
    applyStimulus(100, 7, 14, 2, 1'b0, 1'b1);
    waitOutput(n);
    checkOutput("latency", 32'(n), 32'd18);

    // Sign combinations and boundaries.
    applyStimulus(-100, 7, -14, -2, 1'b0, 1'b1);
    applyStimulus(100, -7, -14, 2, 1'b0, 1'b1);
    applyStimulus(-32768, -1, -32768, 0, 1'b0, 1'b1);
    applyStimulus(-32768, 1, -32768, 0, 1'b0, 1'b1);
    applyStimulus(-7, 2, -3, -1, 1'b0, 1'b1);
    applyStimulus(7, -32768, 0, 7, 1'b0, 1'b1);
    applyStimulus(-32768, -32768, 1, 0, 1'b0, 1'b1);
    applyStimulus(32767, -32768, 0, 32767, 1'b0, 1'b1);

    // Divide by zero.
    applyStimulus(5, 0, -1, 5, 1'b1, 1'b1);
    applyStimulus(-5, 0, -1, -5, 1'b1, 1'b1);

    // Back-pressure: result frozen, new operands ignored while held.
    applyStimulus(1000, 33, 30, 10, 1'b0, 1'b1);
    out_ready = 1'b0;
    waitOutput(n);
    for (int i = 0; i < 5; i++) begin
      dividend = 16'(777 + i);
      divisor  = 16'(3);
      in_valid = (i % 2 == 0);
      @(negedge clk);
      checkOutput("held_out_valid", 32'(out_valid), 32'd1);
      checkOutput("held_in_ready", 32'(in_ready), 32'd0);
      checkOutput("held_quotient", 32'(quotient), 32'd30);
      checkOutput("held_remainder", 32'(remainder), 32'd10);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("idle_after_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_after_release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of an operation discards it.
    applyStimulus(1234, 5, 246, 4, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #2 arst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midreset_quotient", 32'(quotient), 32'd0);
    checkOutput("midreset_remainder", 32'(remainder), 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_reset_quotient", 32'(quotient), 32'd0);

    // Normal operation resumes.
    applyStimulus(9, 4, 2, 1, 1'b0, 1'b1);

    // Drain the scoreboard (bounded).
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
